// File: rtl/aclk_keyentry_pkg.sv
// Shared constants and the entry-state type for the alarm-clock keypad entry block.
package aclk_pkg;

    localparam int KEY_W        = 4;
    localparam int BCD_MAX      = 9;
    localparam int HR_MAX       = 23;
    localparam int MIN_TENS_MAX = 5;

    typedef enum logic [1:0] {
        EMPTY,
        ENTRY,
        FULL
    } entry_state_t;

    // A keypad code is a digit only when it is a legal BCD value.
    function automatic logic is_bcd_key(input logic [KEY_W-1:0] k);
        return k <= KEY_W'(BCD_MAX);
    endfunction

endpackage

// File: rtl/aclk_keyentry_if.sv
// Keypad strobes in, live entry and commit results out.
interface aclk_keyentry_if
    import aclk_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);
    localparam int BUF_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(NUM_DIGITS + 1);

    logic [KEY_W-1:0] key;
    logic             key_valid;
    logic             backspace;
    logic             clear;
    logic             commit;

    logic [BUF_W-1:0] key_buffer;
    logic [CNT_W-1:0] digit_count;
    logic             entry_full;
    logic [BUF_W-1:0] committed_value;
    logic             commit_ok;
    logic             commit_err;

    // Keypad side drives the strobes and observes the entry.
    modport master (
        output key, key_valid, backspace, clear, commit,
        input  key_buffer, digit_count, entry_full, committed_value, commit_ok, commit_err
    );

    // Entry logic consumes the strobes and reports the entry.
    modport slave (
        input  key, key_valid, backspace, clear, commit,
        output key_buffer, digit_count, entry_full, committed_value, commit_ok, commit_err
    );

endinterface

// File: rtl/aclk_keyentry_time_check.sv
// Combinational HH:MM plausibility check on a 4-digit BCD entry.
module aclk_time_check
    import aclk_pkg::*;
(
    input  logic [15:0] hhmm,
    output logic        valid
);
    logic [3:0] hr_tens;
    logic [3:0] hr_units;
    logic [3:0] min_tens;
    logic [3:0] min_units;
    logic [6:0] hours;

    // Split the digits, form the hour number and test every field against its limit.
    always_comb begin
        hr_tens   = hhmm[15:12];
        hr_units  = hhmm[11:8];
        min_tens  = hhmm[7:4];
        min_units = hhmm[3:0];
        hours     = 7'(hr_tens) * 7'd10 + 7'(hr_units);
        valid     = (hr_tens   <= 4'(HR_MAX / 10))
                 && (hr_units  <= 4'(BCD_MAX))
                 && (hours     <= 7'(HR_MAX))
                 && (min_tens  <= 4'(MIN_TENS_MAX))
                 && (min_units <= 4'(BCD_MAX));
    end

endmodule

// File: rtl/aclk_keyentry.sv
// Keypad digit-entry buffer with backspace, clear and a range-checked commit.
module aclk_keyentry
    import aclk_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TIME_CHECK = 1
)(
    input logic            clk,
    input logic            reset,
    aclk_keyentry_if.slave bus
);
    localparam int BUF_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(NUM_DIGITS + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(NUM_DIGITS);
    localparam logic [CNT_W-1:0] ONE_COUNT  = CNT_W'(1);

    entry_state_t     state;
    logic [BUF_W-1:0] key_buffer;
    logic [BUF_W-1:0] committed_value;
    logic [CNT_W-1:0] digit_count;
    logic             commit_ok;
    logic             commit_err;
    logic             range_ok;

    // The time-of-day check only makes sense for a four-digit HHMM entry.
    generate
        if (TIME_CHECK == 1 && NUM_DIGITS == 4) begin : g_time_check
            aclk_time_check u_time_check (
                .hhmm  (key_buffer[15:0]),
                .valid (range_ok)
            );
        end else begin : g_no_time_check
            assign range_ok = 1'b1;
        end
    endgenerate

    // Entry FSM: one strobe acts per cycle, clear > commit > backspace > key.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= EMPTY;
            key_buffer      <= '0;
            digit_count     <= '0;
            committed_value <= '0;
            commit_ok       <= 1'b0;
            commit_err      <= 1'b0;
        end else begin
            commit_ok  <= 1'b0;
            commit_err <= 1'b0;
            if (bus.clear) begin
                key_buffer  <= '0;
                digit_count <= '0;
                state       <= EMPTY;
            end else if (bus.commit) begin
                if (state == FULL && range_ok) begin
                    committed_value <= key_buffer;
                    key_buffer      <= '0;
                    digit_count     <= '0;
                    state           <= EMPTY;
                    commit_ok       <= 1'b1;
                end else begin
                    commit_err <= 1'b1;
                end
            end else if (bus.backspace) begin
                if (state != EMPTY) begin
                    key_buffer  <= {{KEY_W{1'b0}}, key_buffer[BUF_W-1:KEY_W]};
                    digit_count <= digit_count - ONE_COUNT;
                    state       <= (digit_count == ONE_COUNT) ? EMPTY : ENTRY;
                end
            end else if (bus.key_valid) begin
                if (is_bcd_key(bus.key) && state != FULL) begin
                    key_buffer  <= {key_buffer[BUF_W-KEY_W-1:0], bus.key};
                    digit_count <= digit_count + ONE_COUNT;
                    state       <= (digit_count + ONE_COUNT == FULL_COUNT) ? FULL : ENTRY;
                end
            end
        end
    end

    assign bus.key_buffer      = key_buffer;
    assign bus.digit_count     = digit_count;
    assign bus.entry_full      = (state == FULL);
    assign bus.committed_value = committed_value;
    assign bus.commit_ok       = commit_ok;
    assign bus.commit_err      = commit_err;

endmodule

// File: tb/tb_aclk_keyentry.sv
// Scoreboard bench for aclk_keyentry: a 4-digit HH:MM instance and a 6-digit unchecked instance.
module tb_aclk_keyentry;
    import aclk_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    aclk_keyentry_if #(.NUM_DIGITS(4)) bus4 ();
    aclk_keyentry_if #(.NUM_DIGITS(6)) bus6 ();

    aclk_keyentry #(.NUM_DIGITS(4), .TIME_CHECK(1)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    aclk_keyentry #(.NUM_DIGITS(6), .TIME_CHECK(0)) dut6 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus6)
    );

    typedef struct {
        logic [31:0] kb;
        int          cnt;
        bit          full;
        logic [31:0] cv;
        bit          ok;
        bit          err;
    } exp_t;

    exp_t exp_q4[$];
    exp_t exp_q6[$];

    int compared   = 0;
    int mismatched = 0;

    // Reference model: digits stored oldest-first as plain integers.
    int          m_dig [2][8];
    int          m_cnt [2];
    logic [31:0] m_cv  [2];

    function automatic int inst_digits(input int i);
        return (i == 0) ? 4 : 6;
    endfunction

    function automatic logic [31:0] model_value(input int i);
        logic [31:0] v;
        v = 0;
        for (int j = 0; j < m_cnt[i]; j++) v = v * 16 + 32'(m_dig[i][j]);
        return v;
    endfunction

    function automatic bit model_range_ok(input int i);
        int hours;
        if (i != 0) return 1'b1;
        hours = m_dig[i][0] * 10 + m_dig[i][1];
        return (m_dig[i][0] <= 2) && (hours <= 23) && (m_dig[i][2] <= 5);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0;
            m_cv[i]  = 0;
        end
    endtask

    task automatic model_step(input int i, input bit clr, input bit cmt, input bit bs,
                              input bit kv, input int k, output bit ok, output bit err);
        ok  = 1'b0;
        err = 1'b0;
        if (clr) begin
            m_cnt[i] = 0;
        end else if (cmt) begin
            if (m_cnt[i] == inst_digits(i) && model_range_ok(i)) begin
                m_cv[i]  = model_value(i);
                m_cnt[i] = 0;
                ok       = 1'b1;
            end else begin
                err = 1'b1;
            end
        end else if (bs) begin
            if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
        end else if (kv) begin
            if (k <= 9 && m_cnt[i] < inst_digits(i)) begin
                m_dig[i][m_cnt[i]] = k;
                m_cnt[i] = m_cnt[i] + 1;
            end
        end
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic compare_entry(input string tag, input exp_t e, input logic [31:0] kb,
                                 input int cnt, input bit full, input logic [31:0] cv,
                                 input bit ok, input bit err);
        check_output({tag, " key_buffer"},      kb,          e.kb);
        check_output({tag, " digit_count"},     32'(cnt),    32'(e.cnt));
        check_output({tag, " entry_full"},      32'(full),   32'(e.full));
        check_output({tag, " committed_value"}, cv,          e.cv);
        check_output({tag, " commit_ok"},       32'(ok),     32'(e.ok));
        check_output({tag, " commit_err"},      32'(err),    32'(e.err));
    endtask

    // Monitors: one expectation per clocked cycle, compared half a cycle after the edge.
    always @(negedge clk) begin
        exp_t e4;
        if (exp_q4.size() > 0) begin
            e4 = exp_q4.pop_front();
            compare_entry("n4", e4, 32'(bus4.key_buffer), int'(bus4.digit_count), bus4.entry_full,
                          32'(bus4.committed_value), bus4.commit_ok, bus4.commit_err);
        end
    end

    always @(negedge clk) begin
        exp_t e6;
        if (exp_q6.size() > 0) begin
            e6 = exp_q6.pop_front();
            compare_entry("n6", e6, 32'(bus6.key_buffer), int'(bus6.digit_count), bus6.entry_full,
                          32'(bus6.committed_value), bus6.commit_ok, bus6.commit_err);
        end
    end

    task automatic drive_inputs(input bit clr, input bit cmt, input bit bs, input bit kv, input int k);
        bus4.clear = clr; bus4.commit = cmt; bus4.backspace = bs; bus4.key_valid = kv; bus4.key = 4'(k);
        bus6.clear = clr; bus6.commit = cmt; bus6.backspace = bs; bus6.key_valid = kv; bus6.key = 4'(k);
    endtask

    // One cycle of strobes to both instances; the model's predictions go to the scoreboards.
    task automatic apply_stimulus(input bit clr, input bit cmt, input bit bs, input bit kv, input int k);
        exp_t e;
        bit   ok;
        bit   err;
        @(negedge clk);
        drive_inputs(clr, cmt, bs, kv, k);
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            model_step(i, clr, cmt, bs, kv, k, ok, err);
            e.kb   = model_value(i);
            e.cnt  = m_cnt[i];
            e.full = (m_cnt[i] == inst_digits(i));
            e.cv   = m_cv[i];
            e.ok   = ok;
            e.err  = err;
            if (i == 0) exp_q4.push_back(e);
            else        exp_q6.push_back(e);
        end
        #1;
        drive_inputs(0, 0, 0, 0, 0);
    endtask

    task automatic press(input int k);
        apply_stimulus(0, 0, 0, 1, k);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, " n4 key_buffer"},      32'(bus4.key_buffer),      0);
        check_output({tag, " n4 digit_count"},     32'(bus4.digit_count),     0);
        check_output({tag, " n4 entry_full"},      32'(bus4.entry_full),      0);
        check_output({tag, " n4 committed_value"}, 32'(bus4.committed_value), 0);
        check_output({tag, " n4 commit_ok"},       32'(bus4.commit_ok),       0);
        check_output({tag, " n4 commit_err"},      32'(bus4.commit_err),      0);
        check_output({tag, " n6 key_buffer"},      32'(bus6.key_buffer),      0);
        check_output({tag, " n6 digit_count"},     32'(bus6.digit_count),     0);
        check_output({tag, " n6 committed_value"}, 32'(bus6.committed_value), 0);
    endtask

    initial begin
        drive_inputs(0, 0, 0, 0, 0);
        model_reset();
        reset = 1'b1;
        #1;
        check_reset_outputs("power-on reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Valid time fills and commits; then an out-of-range time is refused.
        press(2); press(3); press(5); press(9);
        apply_stimulus(0, 1, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0);
        press(2); press(5); press(0); press(0);
        apply_stimulus(0, 1, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0);

        // Non-digit codes ignored; a full buffer refuses further keys.
        apply_stimulus(1, 0, 0, 0, 0);
        press(1); press(4'hB); press(2);
        apply_stimulus(1, 0, 0, 0, 0);
        press(1); press(2); press(3); press(4); press(5);

        // Backspace down to empty and one past it.
        apply_stimulus(1, 0, 0, 0, 0);
        press(2); press(3); press(5);
        for (int b = 0; b < 4; b++) apply_stimulus(0, 0, 1, 0, 0);

        // Simultaneous strobes resolve by priority.
        press(2); press(3); press(5); press(9);
        apply_stimulus(1, 1, 0, 0, 0);
        press(1); press(2);
        apply_stimulus(0, 0, 1, 1, 7);
        apply_stimulus(0, 1, 1, 1, 3);

        // Reset in the middle of an entry clears everything without a clock edge.
        apply_stimulus(1, 0, 0, 0, 0);
        press(1); press(2);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("mid-entry reset");
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Six-digit fill and commit; the four-digit instance commits 12:34.
        for (int k = 1; k <= 6; k++) press(k);
        apply_stimulus(0, 1, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0);

        // Random legal times keyed and committed.
        for (int t = 0; t < 12; t++) begin
            int hh;
            int mm;
            hh = int'($urandom_range(0, 23));
            mm = int'($urandom_range(0, 59));
            press(hh / 10); press(hh % 10); press(mm / 10); press(mm % 10);
            apply_stimulus(0, 1, 0, 0, 0);
            apply_stimulus(1, 0, 0, 0, 0);
        end

        // Random strobe mixes, including overlapping strobes and non-digit codes.
        for (int c = 0; c < 400; c++) begin
            bit clr;
            bit cmt;
            bit bs;
            bit kv;
            int k;
            clr = ($urandom_range(0, 99) < 4);
            cmt = ($urandom_range(0, 99) < 12);
            bs  = ($urandom_range(0, 99) < 15);
            kv  = ($urandom_range(0, 99) < 70);
            k   = ($urandom_range(0, 99) < 85) ? int'($urandom_range(0, 9)) : int'($urandom_range(10, 15));
            apply_stimulus(clr, cmt, bs, kv, k);
        end

        for (int w = 0; w < 20 && (exp_q4.size() > 0 || exp_q6.size() > 0); w++) @(negedge clk);
        compared++;
        if (exp_q4.size() > 0 || exp_q6.size() > 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard drain: %0d/%0d entries left, required 0/0",
                     exp_q4.size(), exp_q6.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
